// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register outstanding-write counters driving the ID-stage stall (hazard) and issue_fire; optional WAW stall under `HAZARD_SB_WAW_CHECK_EN.
// Ports: clk, rst (sync, active-high); src/src_valid, dest, wb_en, issue_valid, freeze from ID;
// ret_valid/ret_dest from WB; kill_valid/kill_dest from flush; hazard, issue_fire, reg_busy, underflow_err out.
module hazard_scoreboard #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         dest,
  input  logic                      wb_en,
  input  logic                      issue_valid,
  input  logic                      freeze,
  input  logic                      ret_valid,
  input  logic [REG_AW-1:0]         ret_dest,
  input  logic                      kill_valid,
  input  logic [REG_AW-1:0]         kill_dest,
  output logic                      hazard,
  output logic                      issue_fire,
  output logic [2**REG_AW-1:0]      reg_busy,
  output logic                      underflow_err
);
  localparam int NUM_REGS = 2**REG_AW;
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [CNT_W-1:0] count [NUM_REGS];
  logic [CNT_W-1:0] count_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] uf;
  logic raw, waw;
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_valid[i] && count[src[i*REG_AW +: REG_AW]] != '0) raw = 1'b1;
`ifdef HAZARD_SB_WAW_CHECK_EN
    waw = wb_en && count[dest] != '0;
`else
    waw = wb_en && count[dest] == CMAX;
`endif
    hazard     = issue_valid && (raw || waw);
    issue_fire = issue_valid && !hazard && !freeze;
  end
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic [CNT_W:0] sum;
    logic [1:0] dec;
    assign sum = {1'b0, count[r]} + (CNT_W+1)'(issue_fire && wb_en && dest == REG_AW'(r));
    assign dec = 2'(ret_valid && ret_dest == REG_AW'(r)) + 2'(kill_valid && kill_dest == REG_AW'(r));
    // A decrement beyond what is outstanding clamps at zero and flags the error.
    assign uf[r] = (CNT_W+1)'(dec) > sum;
    assign count_nxt[r] = uf[r] ? '0 : CNT_W'(sum - (CNT_W+1)'(dec));
    assign reg_busy[r] = count[r] != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
      underflow_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) count[r] <= count_nxt[r];
      if (|uf) underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus randomized run against a counting reference model.
module tb_hazard_scoreboard;
  localparam int NR = 16, MAXC = 3;
`ifdef HAZARD_SB_WAW_CHECK_EN
  localparam bit WAW = 1'b1;
`else
  localparam bit WAW = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, wb_en, issue_valid, freeze, ret_valid, kill_valid;
  logic [7:0] src;
  logic [1:0] src_valid;
  logic [3:0] dest, ret_dest, kill_dest;
  logic hazard, issue_fire, underflow_err;
  logic [15:0] reg_busy;
  int total = 0, bad = 0;
  int cnt [NR];
  bit muf;
  typedef struct {
    logic rst, iv;
    logic [1:0] sv;
    logic [3:0] s0, s1;
    logic wb;
    logic [3:0] dst;
    logic frz, rv;
    logic [3:0] rd;
    logic kv;
    logic [3:0] kd;
    logic hz, fire;
    logic [15:0] busy;
    logic uf;
  } vec_t;
  vec_t tbl [23];
  vec_t v;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .src(src), .src_valid(src_valid), .dest(dest), .wb_en(wb_en),
    .issue_valid(issue_valid), .freeze(freeze), .ret_valid(ret_valid), .ret_dest(ret_dest),
    .kill_valid(kill_valid), .kill_dest(kill_dest), .hazard(hazard), .issue_fire(issue_fire),
    .reg_busy(reg_busy), .underflow_err(underflow_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    @(negedge clk);
    rst = x.rst; issue_valid = x.iv; src_valid = x.sv; src = {x.s1, x.s0};
    wb_en = x.wb; dest = x.dst; freeze = x.frz;
    ret_valid = x.rv; ret_dest = x.rd; kill_valid = x.kv; kill_dest = x.kd;
    #1;
  endtask

  function automatic bit m_hz();
    bit used = (src_valid[0] && cnt[src[3:0]] != 0) || (src_valid[1] && cnt[src[7:4]] != 0);
    bit wr = wb_en && (WAW ? cnt[dest] != 0 : cnt[dest] == MAXC);
    return issue_valid && (used || wr);
  endfunction

  function automatic bit m_fire();
    return issue_valid && !m_hz() && !freeze;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    for (int r = 0; r < NR; r++) b[r] = cnt[r] != 0;
    return b;
  endfunction

  task automatic m_tick();
    int n;
    bit f;
    @(posedge clk);
    f = m_fire();
    for (int r = 0; r < NR; r++) begin
      if (rst) begin
        cnt[r] = 0;
      end else begin
        n = cnt[r] + int'(f && wb_en && dest == r) - int'(ret_valid && ret_dest == r)
            - int'(kill_valid && kill_dest == r);
        if (n < 0) begin n = 0; muf = 1'b1; end
        cnt[r] = n;
      end
    end
    if (rst) muf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_hazard"}, 32'(hazard), 32'(m_hz()));
    chk({tag, "_fire"}, 32'(issue_fire), 32'(m_fire()));
    chk({tag, "_busy"}, 32'(reg_busy), 32'(m_busy()));
    chk({tag, "_uf"}, 32'(underflow_err), 32'(muf));
  endtask

  initial begin
    // rst iv sv s0 s1 wb dst frz rv rd kv kd | hz fire busy uf
    tbl[0]  = '{0,1,2'b01,3,0,1,5,0,0,0,0,0, 0,1,16'h0000,0};
    tbl[1]  = '{0,1,2'b01,5,0,0,0,0,0,0,0,0, 1,0,16'h0020,0};
    tbl[2]  = '{0,1,2'b01,5,0,0,0,0,1,5,0,0, 1,0,16'h0020,0};
    tbl[3]  = '{0,1,2'b01,5,0,0,0,0,0,0,0,0, 0,1,16'h0000,0};
    tbl[4]  = '{0,1,2'b00,0,0,1,7,0,0,0,0,0, 0,1,16'h0000,0};
    tbl[5]  = '{0,1,2'b01,0,7,0,0,0,0,0,0,0, 0,1,16'h0080,0};
    tbl[6]  = '{0,1,2'b00,0,0,1,2,0,0,0,0,0, 0,1,16'h0080,0};
    tbl[7]  = '{0,1,2'b00,0,0,1,2,0,1,2,0,0, 0,1,16'h0084,0};
    tbl[8]  = '{0,1,2'b00,0,0,1,2,0,0,0,0,0, 0,1,16'h0084,0};
    tbl[9]  = '{0,0,2'b00,0,0,0,0,0,1,2,1,2, 0,0,16'h0084,0};
    tbl[10] = '{0,0,2'b00,0,0,0,0,0,1,7,0,0, 0,0,16'h0080,0};
    tbl[11] = '{0,1,2'b00,0,0,1,4,0,0,0,0,0, 0,1,16'h0000,0};
    tbl[12] = '{0,1,2'b00,0,0,1,4,0,0,0,0,0, 0,1,16'h0010,0};
    tbl[13] = '{0,1,2'b00,0,0,1,4,0,0,0,0,0, 0,1,16'h0010,0};
    tbl[14] = '{0,1,2'b00,0,0,1,4,0,0,0,0,0, 1,0,16'h0010,0};
    tbl[15] = '{0,1,2'b00,0,0,1,8,1,1,4,0,0, 0,0,16'h0010,0};
    tbl[16] = '{0,0,2'b00,0,0,0,0,0,1,9,0,0, 0,0,16'h0010,0};
    tbl[17] = '{0,0,2'b00,0,0,0,0,0,0,0,0,0, 0,0,16'h0010,1};
    tbl[18] = '{0,0,2'b00,0,0,0,0,0,1,4,1,4, 0,0,16'h0010,1};
    tbl[19] = '{0,1,2'b00,0,0,1,6,0,0,0,0,0, 0,1,16'h0000,1};
    tbl[20] = '{0,1,2'b00,0,0,1,6,0,0,0,0,0, 0,1,16'h0040,1};
    tbl[21] = '{1,0,2'b00,0,0,0,0,0,0,0,0,0, 0,0,16'h0040,1};
    tbl[22] = '{0,0,2'b00,0,0,0,0,0,0,0,0,0, 0,0,16'h0000,0};
    v = '{1,0,2'b00,0,0,0,0,0,0,0,0,0, 0,0,16'h0000,0};
    drive(v);
    m_tick();
`ifndef HAZARD_SB_WAW_CHECK_EN
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i]);
      chk($sformatf("vec%0d_hazard", i), 32'(hazard), 32'(tbl[i].hz));
      chk($sformatf("vec%0d_fire", i), 32'(issue_fire), 32'(tbl[i].fire));
      chk($sformatf("vec%0d_busy", i), 32'(reg_busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_uf", i), 32'(underflow_err), 32'(tbl[i].uf));
      m_tick();
    end
`endif
    // Second write to a register with one write outstanding: stalls only with the WAW check.
    v = '{1,0,2'b00,0,0,0,0,0,0,0,0,0, 0,0,16'h0000,0};
    drive(v);
    m_tick();
    v = '{0,1,2'b00,0,0,1,6,0,0,0,0,0, 0,1,16'h0000,0};
    drive(v);
    chk("waw_first_fire", 32'(issue_fire), 32'd1);
    m_tick();
    drive(v);
    chk("waw_second_hazard", 32'(hazard), 32'(WAW));
    chk("waw_second_fire", 32'(issue_fire), 32'(!WAW));
    chk("waw_busy", 32'(reg_busy), 32'h0040);
    m_tick();
    for (int i = 0; i < 3000; i++) begin
      v.rst = $urandom_range(0, 63) == 0;
      v.iv  = $urandom_range(0, 3) != 0;
      v.sv  = 2'($urandom_range(0, 3));
      v.s0  = 4'($urandom_range(0, 4));
      v.s1  = 4'($urandom_range(0, 15));
      v.wb  = $urandom_range(0, 3) != 0;
      v.dst = 4'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
      v.frz = $urandom_range(0, 7) == 0;
      v.rv  = $urandom_range(0, 2) == 0;
      v.rd  = 4'($urandom_range(0, 4));
      v.kv  = $urandom_range(0, 5) == 0;
      v.kd  = 4'($urandom_range(0, 4));
      drive(v);
      check_model($sformatf("rnd%0d", i));
      m_tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, stateful successor to the ID-stage hazard detector. It tracks how many writes are outstanding to each architectural register, using a per-register saturating counter. It raises `hazard` while any enabled source operand (or, optionally, the destination) still has an outstanding write. It sits between the ID stage, which issues, and the WB stage and flush logic, which retire or kill writes. It replaces the fixed EXE/MEM destination compare, so pipeline depth and variable-latency units no longer need dedicated compare ports.

## Interface
Parameters:
- `REG_AW`, 4: register address width; `NUM_REGS = 2**REG_AW`.
- `NUM_SRC`, 2: number of source operand ports.
- `CNT_W`, 2: per-register outstanding-write counter width; max outstanding per register is `2**CNT_W - 1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src`  in  NUM_SRC*REG_AW  packed source register addresses; port i is at bits [i*REG_AW +: REG_AW].
- `src_valid`  in  NUM_SRC  per-port "source used" (generalises `has_src2`).
- `dest`  in  REG_AW  destination of the instruction in ID.
- `wb_en`  in  1  instruction in ID writes `dest`.
- `issue_valid`  in  1  a valid instruction is present in ID.
- `freeze`  in  1  pipeline frozen; no issue is accepted.
- `ret_valid`, `ret_dest`  in  1 / REG_AW  WB-stage write completes.
- `kill_valid`, `kill_dest`  in  1 / REG_AW  squashed in-flight writer (branch flush), one per cycle.
- `hazard`  out  1  stall ID; combinational.
- `issue_fire`  out  1  `issue_valid & ~hazard & ~freeze`.
- `reg_busy`  out  NUM_REGS  bit r = (count[r] != 0); registered state.
- `underflow_err`  out  1  sticky; set when a retire or kill targets a zero count.

## Operation
- State: `count[r]`, CNT_W bits, for each r in 0..NUM_REGS-1; and `underflow_err`.
- `hazard` = `issue_valid` & (any i with `src_valid[i]` & count[src_i] != 0, or `wb_en` & count[dest] == max). The `==max` term is saturation protection.
- `hazard` is evaluated against current-cycle counts only. A retire in the same cycle does not clear the hazard; the stall lasts until the next cycle.
- Per-register next-count update, each cycle:
  - count + inc − dec_r − dec_k.
  - inc = `issue_fire & wb_en & dest==r`.
  - dec_r = `ret_valid & ret_dest==r`.
  - dec_k = `kill_valid & kill_dest==r`.
- Simultaneous events on the same register:
  - Issue and retire: net unchanged.
  - Retire and kill: subtract 2.
  - Any order of the three events is legal.
- Underflow: if the requested decrement exceeds the current count plus inc, the count clamps to 0 and `underflow_err` sets. It stays set until `rst`.
- Increments never overflow, because the `==max` hazard term blocks them.
- `freeze` suppresses `issue_fire`. Retire and kill still update counts while frozen.
- `issue_valid`=0 forces `hazard`=0 and `issue_fire`=0.

## Timing
- Reset, synchronous on `rst`=1 at the clock edge:
  - All counts go to 0.
  - `reg_busy`=0 and `underflow_err`=0.
  - `hazard` and `issue_fire` follow their inputs combinationally, with counts at 0.
- `rst` asserted mid-operation discards all outstanding tracking at that edge. Retire and kill in the same cycle are ignored.
- Count and `reg_busy` latency: an issue in cycle N is visible as busy in cycle N+1. A retire in cycle N clears busy in N+1, and the dependent instruction issues in N+1.
- `hazard` and `issue_fire` have zero latency from inputs.
- No handshake beyond `issue_fire`. The producer holds the ID contents while `hazard` or `freeze` is high.

## Configuration
- `HAZARD_SB_WAW_CHECK_EN` defined:
  - `hazard` also asserts when `wb_en` & count[dest] != 0, i.e. a write-after-write stall.
  - With this check, count never exceeds 1, though CNT_W is still honoured.
- Not defined:
  - Only RAW and saturation hazards apply.
  - Multiple outstanding writes per register are allowed, up to max.

## Test plan
- Reset: after `rst`, check `reg_busy`=0, `underflow_err`=0. With `issue_valid`=1, src0=3 (`src_valid`=01), `wb_en`=1, dest=5, check `hazard`=0, `issue_fire`=1; next cycle `reg_busy`=0x0020.
- RAW stall and release: with r5 busy, issue src0=5 → `hazard`=1 for each cycle until `ret_valid`/`ret_dest`=5 in cycle N; `hazard`=0 and `issue_fire`=1 in N+1.
- Unused source: r7 busy, src1=7 with `src_valid[1]`=0 → `hazard`=0.
- Simultaneous events: count[2]=1; in the same cycle issue dest=2 and retire r2 → count stays 1. Then retire r2 and kill r2 with count[2]=2 → 0, `underflow_err`=0.
- Saturation and underflow: with CNT_W=2, issue dest=4 three times → `hazard`=1 on the fourth issue, even with no sources. Retire r9 with count 0 → `underflow_err`=1 and stays 1 until `rst`.
- Freeze and macro:
  - `freeze`=1 with a clean issue → `issue_fire`=0, counts unchanged; a retire during freeze still decrements.
  - With `HAZARD_SB_WAW_CHECK_EN`: count[6]=1, issue dest=6 with no sources → `hazard`=1.
  - Without the macro, the same issue → `hazard`=0.
